// File: rtl/multicycle_controller_pkg.sv
// multicycle_controller_pkg: shared types, encodings and decode helpers for the multi-cycle controller
package multicycle_controller_pkg;
  localparam int OPC_W = 4;
  localparam int ALU_W = 3;
  typedef enum logic [OPC_W-1:0] {
    PUT, STORE, LB, SB, ADD, SUB, AND, XOR, SFL, SFR, CMP, GTR, BTR, JMP, HALT = '1
  } Instr_O;
  typedef enum logic [ALU_W-1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR, ALU_SFL, ALU_SFR, ALU_EQU, ALU_GTR
  } Alu_Op;
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
  } Ctrl_State;
  localparam logic [1:0] ACC_IMM = 2'b00;
  localparam logic [1:0] ACC_REG = 2'b01;
  localparam logic [1:0] ACC_MEM = 2'b10;
  localparam logic [1:0] ACC_ALU = 2'b11;
  typedef struct packed {
    Alu_Op      aluop;
    logic [1:0] accdata;
    logic       regwrite;
    logic       accwrite;
    logic       memwrite;
    logic       br;
    logic       jmp;
    logic       is_mem;
    logic       is_halt;
    logic       illegal;
  } Ctrl_Word;
  function automatic Alu_Op alu_of(input Instr_O op);
    case (op)
      SUB:     return ALU_SUB;
      AND:     return ALU_AND;
      XOR:     return ALU_XOR;
      SFL:     return ALU_SFL;
      SFR:     return ALU_SFR;
      CMP:     return ALU_EQU;
      GTR:     return ALU_GTR;
      default: return ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: instruction fetch handshake, datapath strobes and status of the controller
interface multicycle_controller_if #(
  parameter int OP_W    = 4,
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 16
);
  logic               start;
  logic               instr_valid;
  logic               instr_ready;
  logic               TYP;
  logic [OP_W-1:0]    OP;
  logic               pc_en;
  logic               br_ctrl;
  logic               jmp_ctrl;
  logic               regwrite_ctrl;
  logic               accwrite_ctrl;
  logic               memwrite_ctrl;
  logic               memread_ctrl;
  logic [ALUOP_W-1:0] aluop_ctrl;
  logic [1:0]         accdata_ctrl;
  logic               busy;
  logic               done;
  logic               illegal;
  logic [CNT_W-1:0]   retired;
  modport master (
    output start, instr_valid, TYP, OP,
    input  instr_ready, pc_en, br_ctrl, jmp_ctrl, regwrite_ctrl, accwrite_ctrl,
           memwrite_ctrl, memread_ctrl, aluop_ctrl, accdata_ctrl, busy, done, illegal, retired
  );
  modport slave (
    input  start, instr_valid, TYP, OP,
    output instr_ready, pc_en, br_ctrl, jmp_ctrl, regwrite_ctrl, accwrite_ctrl,
           memwrite_ctrl, memread_ctrl, aluop_ctrl, accdata_ctrl, busy, done, illegal, retired
  );
endinterface

// File: rtl/multicycle_controller_instr_decoder.sv
// multicycle_controller_instr_decoder: combinational map from the latched instruction to a control word
module multicycle_controller_instr_decoder
  import multicycle_controller_pkg::*;
(
  input  logic     typ_i,
  input  Instr_O   op_i,
  output Ctrl_Word cw_o
);
  always_comb begin
    cw_o = '0;
    cw_o.accwrite = typ_i;
    if (!typ_i)
      case (op_i)
        PUT:   begin cw_o.accwrite = 1'b1; cw_o.accdata = ACC_REG; end
        STORE: cw_o.regwrite = 1'b1;
        LB:    begin cw_o.accwrite = 1'b1; cw_o.accdata = ACC_MEM; cw_o.is_mem = 1'b1; end
        SB:    begin cw_o.memwrite = 1'b1; cw_o.is_mem = 1'b1; end
        ADD, SUB, AND, XOR, SFL, SFR, CMP, GTR: begin
          cw_o.accwrite = 1'b1;
          cw_o.accdata = ACC_ALU;
          cw_o.aluop = alu_of(op_i);
        end
        BTR:   cw_o.br = 1'b1;
        JMP:   cw_o.jmp = 1'b1;
        HALT:  cw_o.is_halt = 1'b1;
        default: cw_o.illegal = 1'b1;
      endcase
  end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB sequencer for the accumulator datapath.
// Every output is a flop loaded from the next state, so strobes line up with the state they belong to.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OP_W    = OPC_W,
  parameter int ALUOP_W = ALU_W,
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input logic CLK,
  input logic reset,
  multicycle_controller_if.slave bus
);
  localparam int LW = MEM_LAT > 1 ? $clog2(MEM_LAT) : 1;
  Ctrl_State state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic typ_q;
  logic [OP_W-1:0] op_q;
  Ctrl_Word cw;
  logic xw, wb;
  logic ready_q, pc_q, br_q, jmp_q, rw_q, aw_q, mw_q, mr_q, busy_q, done_q, ill_q;
  logic [ALUOP_W-1:0] alu_q;
  logic [1:0] acc_q;
  logic [CNT_W-1:0] ret_q;
  multicycle_controller_instr_decoder u_dec (.typ_i(typ_q), .op_i(Instr_O'(op_q)), .cw_o(cw));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE, S_HALTED: state_d = bus.start ? S_FETCH : state_q;
      S_FETCH:  state_d = bus.instr_valid ? S_DECODE : S_FETCH;
      S_DECODE: state_d = cw.is_halt ? S_HALTED : S_EXEC;
      S_EXEC: begin
        state_d = cw.is_mem ? S_MEM : S_WB;
        cnt_d = cw.is_mem ? LW'(MEM_LAT - 1) : cnt_q;
      end
      S_MEM: begin
        state_d = cnt_q == '0 ? S_WB : S_MEM;
        cnt_d = cnt_q == '0 ? cnt_q : cnt_q - LW'(1);
      end
      default: state_d = S_FETCH;
    endcase
  end
  assign xw = state_d inside {S_EXEC, S_MEM, S_WB};
  assign wb = state_d == S_WB;
  always_ff @(posedge CLK or posedge reset)
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      typ_q   <= 1'b0;
      op_q    <= '0;
      ready_q <= 1'b0;
      pc_q    <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      rw_q    <= 1'b0;
      aw_q    <= 1'b0;
      mw_q    <= 1'b0;
      mr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      alu_q   <= ALUOP_W'(ALU_ADD);
      acc_q   <= ACC_IMM;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_FETCH && bus.instr_valid) begin
        typ_q <= bus.TYP;
        op_q  <= bus.OP;
      end
      ready_q <= state_d == S_FETCH;
      pc_q    <= wb;
      br_q    <= wb && cw.br;
      jmp_q   <= wb && cw.jmp;
      rw_q    <= wb && cw.regwrite;
      aw_q    <= wb && cw.accwrite;
      // a store lands only in the last cycle of the memory wait
      mw_q    <= state_d == S_MEM && cnt_d == '0 && cw.memwrite;
      mr_q    <= state_d == S_MEM && cw.is_mem && !cw.memwrite;
      busy_q  <= state_d inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
      done_q  <= state_d == S_HALTED;
      ill_q   <= ill_q || (state_q == S_DECODE && cw.illegal);
      alu_q   <= xw ? ALUOP_W'(cw.aluop) : ALUOP_W'(ALU_ADD);
      acc_q   <= xw ? cw.accdata : ACC_IMM;
      ret_q   <= ret_q + CNT_W'(state_q == S_WB && !(&ret_q));
    end
  assign bus.instr_ready   = ready_q;
  assign bus.pc_en         = pc_q;
  assign bus.br_ctrl       = br_q;
  assign bus.jmp_ctrl      = jmp_q;
  assign bus.regwrite_ctrl = rw_q;
  assign bus.accwrite_ctrl = aw_q;
  assign bus.memwrite_ctrl = mw_q;
  assign bus.memread_ctrl  = mr_q;
  assign bus.aluop_ctrl    = alu_q;
  assign bus.accdata_ctrl  = acc_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.illegal       = ill_q;
  assign bus.retired       = ret_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed per-cycle checks of the controller with MEM_LAT=3
module tb_multicycle_controller;
  import multicycle_controller_pkg::*;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  multicycle_controller_if #(.OP_W(4), .ALUOP_W(3), .CNT_W(16)) bus ();
  multicycle_controller #(.OP_W(4), .ALUOP_W(3), .MEM_LAT(3), .CNT_W(16)) dut (
    .CLK(clk), .reset(rst), .bus(bus.slave)
  );
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] obs;
  logic [15:0] tr [16];
  logic [15:0] ex [16];
  assign obs = {bus.instr_ready, bus.pc_en, bus.br_ctrl, bus.jmp_ctrl, bus.regwrite_ctrl,
                bus.accwrite_ctrl, bus.memwrite_ctrl, bus.memread_ctrl, bus.aluop_ctrl,
                bus.accdata_ctrl, bus.busy, bus.done, bus.illegal};
  function automatic logic [15:0] v(input logic rdy, pc, br, jmp, rw, aw, mw, mr,
                                    input logic [2:0] alu, input logic [1:0] acc,
                                    input logic bsy, dn, il);
    return {rdy, pc, br, jmp, rw, aw, mw, mr, alu, acc, bsy, dn, il};
  endfunction
  function automatic logic [15:0] fv(input logic il);
    return v(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, ACC_IMM, 1'b1, 1'b0, il);
  endfunction
  function automatic logic [15:0] bv(input logic [2:0] alu, input logic [1:0] acc,
                                     input logic mw, mr, il);
    return v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mw, mr, alu, acc, 1'b1, 1'b0, il);
  endfunction
  function automatic logic [15:0] wv(input logic br, jmp, rw, aw, input logic [2:0] alu,
                                     input logic [1:0] acc, input logic il);
    return v(1'b0, 1'b1, br, jmp, rw, aw, 1'b0, 1'b0, alu, acc, 1'b1, 1'b0, il);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic go;
    bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
  endtask
  task automatic test_reset;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.instr_valid = 1'b0;
    bus.TYP = 1'b0;
    bus.OP = '0;
    tick;
    tick;
    n_vec++;
    if (obs !== 16'h0) begin n_err++; $display("FAIL reset_out got %h want %h", obs, 16'h0); end
    n_vec++;
    if (bus.retired !== 16'd0) begin n_err++; $display("FAIL reset_retired got %0d want 0", bus.retired); end
    rst = 1'b0;
    bus.instr_valid = 1'b1;
    tick;
    tick;
    n_vec++;
    if (obs !== 16'h0) begin n_err++; $display("FAIL idle_hold got %h want %h", obs, 16'h0); end
    bus.instr_valid = 1'b0;
  endtask
  task automatic test_mtype;
    go;
    bus.instr_valid = 1'b1;
    bus.TYP = 1'b1;
    bus.OP = 4'h5;
    ex[0] = fv(1'b0);
    ex[1] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[2] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[3] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, ACC_IMM, 1'b0);
    ex[4] = fv(1'b0);
    for (int i = 0; i < 5; i++) begin
      tr[i] = obs;
      if (i == 3) begin
        n_vec++;
        if (bus.retired !== 16'd0) begin n_err++; $display("FAIL mtype_ret_wb got %0d want 0", bus.retired); end
      end
      if (i == 1) bus.instr_valid = 1'b0;
      if (i < 4) tick;
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL mtype c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd1) begin n_err++; $display("FAIL mtype_ret got %0d want 1", bus.retired); end
    bus.TYP = 1'b0;
  endtask
  task automatic test_back_to_back;
    bus.instr_valid = 1'b1;
    bus.OP = ADD;
    ex[0] = fv(1'b0);
    ex[1] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[2] = bv(ALU_ADD, ACC_ALU, 1'b0, 1'b0, 1'b0);
    ex[3] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, ACC_ALU, 1'b0);
    ex[4] = fv(1'b0);
    ex[5] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[6] = bv(ALU_SUB, ACC_ALU, 1'b0, 1'b0, 1'b0);
    ex[7] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_SUB, ACC_ALU, 1'b0);
    ex[8] = fv(1'b0);
    for (int i = 0; i < 9; i++) begin
      tr[i] = obs;
      if (i == 3) bus.OP = SUB;
      if (i == 7) bus.instr_valid = 1'b0;
      if (i < 8) tick;
    end
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL b2b c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd3) begin n_err++; $display("FAIL b2b_ret got %0d want 3", bus.retired); end
  endtask
  task automatic test_mem;
    bus.instr_valid = 1'b1;
    bus.OP = SB;
    ex[0] = fv(1'b0);
    for (int i = 1; i < 5; i++) ex[i] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[5] = bv(ALU_ADD, ACC_IMM, 1'b1, 1'b0, 1'b0);
    ex[6] = wv(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, ACC_IMM, 1'b0);
    ex[7] = fv(1'b0);
    for (int i = 0; i < 8; i++) begin
      tr[i] = obs;
      if (i == 1) bus.instr_valid = 1'b0;
      if (i < 7) tick;
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL sb c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd4) begin n_err++; $display("FAIL sb_ret got %0d want 4", bus.retired); end
    bus.instr_valid = 1'b1;
    bus.OP = LB;
    ex[0] = fv(1'b0);
    ex[1] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[2] = bv(ALU_ADD, ACC_MEM, 1'b0, 1'b0, 1'b0);
    for (int i = 3; i < 6; i++) ex[i] = bv(ALU_ADD, ACC_MEM, 1'b0, 1'b1, 1'b0);
    ex[6] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, ACC_MEM, 1'b0);
    ex[7] = fv(1'b0);
    for (int i = 0; i < 8; i++) begin
      tr[i] = obs;
      if (i == 1) bus.instr_valid = 1'b0;
      if (i < 7) tick;
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL lb c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd5) begin n_err++; $display("FAIL lb_ret got %0d want 5", bus.retired); end
  endtask
  task automatic test_stall;
    bus.OP = PUT;
    for (int i = 0; i < 6; i++) ex[i] = fv(1'b0);
    ex[6] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[7] = bv(ALU_ADD, ACC_REG, 1'b0, 1'b0, 1'b0);
    ex[8] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, ACC_REG, 1'b0);
    ex[9] = fv(1'b0);
    for (int i = 0; i < 10; i++) begin
      tr[i] = obs;
      if (i == 5) bus.instr_valid = 1'b1;
      if (i == 6) bus.instr_valid = 1'b0;
      if (i < 9) tick;
    end
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL stall c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd6) begin n_err++; $display("FAIL stall_ret got %0d want 6", bus.retired); end
  endtask
  task automatic test_o_types;
    Instr_O ops [7];
    logic [2:0] alus [7];
    logic [1:0] accs [7];
    logic [3:0] fl [7];
    ops  = '{STORE, BTR, JMP, XOR, SFR, CMP, GTR};
    alus = '{ALU_ADD, ALU_ADD, ALU_ADD, ALU_XOR, ALU_SFR, ALU_EQU, ALU_GTR};
    accs = '{ACC_IMM, ACC_IMM, ACC_IMM, ACC_ALU, ACC_ALU, ACC_ALU, ACC_ALU};
    fl   = '{4'b0010, 4'b1000, 4'b0100, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    for (int k = 0; k < 7; k++) begin
      bus.instr_valid = 1'b1;
      bus.OP = ops[k];
      tick;
      bus.instr_valid = 1'b0;
      tick;
      n_vec++;
      if (obs !== bv(alus[k], accs[k], 1'b0, 1'b0, 1'b0)) begin
        n_err++;
        $display("FAIL otype_exec op%0d got %h want %h", ops[k], obs, bv(alus[k], accs[k], 1'b0, 1'b0, 1'b0));
      end
      tick;
      n_vec++;
      if (obs !== wv(fl[k][3], fl[k][2], fl[k][1], fl[k][0], alus[k], accs[k], 1'b0)) begin
        n_err++;
        $display("FAIL otype_wb op%0d got %h want %h", ops[k], obs,
                 wv(fl[k][3], fl[k][2], fl[k][1], fl[k][0], alus[k], accs[k], 1'b0));
      end
      tick;
    end
    n_vec++;
    if (bus.retired !== 16'd13) begin n_err++; $display("FAIL otype_ret got %0d want 13", bus.retired); end
  endtask
  task automatic test_halt;
    bus.instr_valid = 1'b1;
    bus.OP = HALT;
    ex[0] = fv(1'b0);
    ex[1] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[2] = v(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, ACC_IMM, 1'b0, 1'b1, 1'b0);
    ex[3] = ex[2];
    ex[4] = fv(1'b0);
    for (int i = 0; i < 5; i++) begin
      tr[i] = obs;
      if (i == 1) bus.instr_valid = 1'b0;
      if (i == 3) begin
        n_vec++;
        if (bus.retired !== 16'd13) begin n_err++; $display("FAIL halt_ret got %0d want 13", bus.retired); end
        bus.start = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (i < 4) tick;
    end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL halt c%0d got %h want %h", i, tr[i], ex[i]); end
    end
  endtask
  task automatic test_illegal;
    bus.instr_valid = 1'b1;
    bus.OP = 4'hE;
    ex[0] = fv(1'b0);
    ex[1] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b0);
    ex[2] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b1);
    ex[3] = wv(1'b0, 1'b0, 1'b0, 1'b0, ALU_ADD, ACC_IMM, 1'b1);
    ex[4] = fv(1'b1);
    ex[5] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b1);
    ex[6] = bv(ALU_ADD, ACC_ALU, 1'b0, 1'b0, 1'b1);
    ex[7] = wv(1'b0, 1'b0, 1'b0, 1'b1, ALU_ADD, ACC_ALU, 1'b1);
    ex[8] = fv(1'b1);
    for (int i = 0; i < 9; i++) begin
      tr[i] = obs;
      if (i == 3) bus.OP = ADD;
      if (i == 7) bus.instr_valid = 1'b0;
      if (i < 8) tick;
    end
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL illegal c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    n_vec++;
    if (bus.retired !== 16'd15) begin n_err++; $display("FAIL illegal_ret got %0d want 15", bus.retired); end
  endtask
  task automatic test_reset_mid;
    bus.instr_valid = 1'b1;
    bus.OP = SB;
    ex[0] = fv(1'b1);
    for (int i = 1; i < 4; i++) ex[i] = bv(ALU_ADD, ACC_IMM, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tr[i] = obs;
      if (i == 1) bus.instr_valid = 1'b0;
      if (i < 3) tick;
    end
    #1 rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== 16'h0) begin n_err++; $display("FAIL rstmid_out got %h want %h", obs, 16'h0); end
    n_vec++;
    if (bus.retired !== 16'd0) begin n_err++; $display("FAIL rstmid_ret got %0d want 0", bus.retired); end
    tick;
    tick;
    rst = 1'b0;
    for (int i = 4; i < 8; i++) begin
      ex[i] = 16'h0;
      tick;
      tr[i] = obs;
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (tr[i] !== ex[i]) begin n_err++; $display("FAIL rstmid c%0d got %h want %h", i, tr[i], ex[i]); end
    end
    go;
    n_vec++;
    if (obs !== fv(1'b0)) begin n_err++; $display("FAIL rstmid_restart got %h want %h", obs, fv(1'b0)); end
  endtask
  initial begin
    test_reset;
    test_mtype;
    test_back_to_back;
    test_mem;
    test_stall;
    test_o_types;
    test_halt;
    test_illegal;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
